// File: rtl/debounced_input_port.sv
// rtl/debounced_input_port.sv - synchronized, debounced switch/button port with status and sticky-edge registers
module debounced_input_port #(
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter logic [15:0] BASE_ADDR       = 16'hFFF0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  sw,
    input  logic        btn,
    input  logic [15:0] addr,
    input  logic        dread,
    input  logic        dwrite,
    input  logic [15:0] dwdata,
    output logic [15:0] rdata,
    output logic        hit,
    output logic        event_pending
);

    localparam logic [15:0] EDGE_ADDR = BASE_ADDR + 16'd2;
    // The toggle happens on the edge where the count would reach DEBOUNCE_CYCLES.
    localparam logic [15:0] DB_LAST   = 16'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {STABLE, COUNTING} state_t;

    logic [2:0] raw;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] debounced;
    logic [2:0] level_next;
    logic [2:0] rise;
    logic [2:0] clr;
    logic [2:0] edge_q;

    assign raw = {btn, sw};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 3'b000;
            sync2 <= 3'b000;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_db
        state_t      state_q;
        state_t      state_d;
        logic [15:0] cnt_q;
        logic [15:0] cnt_d;
        logic        lvl_q;
        logic        lvl_d;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= STABLE;
                cnt_q   <= 16'd0;
                lvl_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                lvl_q   <= lvl_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            lvl_d   = lvl_q;
            case (state_q)
                STABLE: begin
                    if (sync2[i] != lvl_q) begin
                        state_d = COUNTING;
                        cnt_d   = 16'd1;
                    end
                end
                COUNTING: begin
                    if (sync2[i] == lvl_q) begin
                        state_d = STABLE;
                        cnt_d   = 16'd0;
                    end else if (cnt_q == DB_LAST) begin
                        lvl_d   = ~lvl_q;
                        state_d = STABLE;
                        cnt_d   = 16'd0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_d = STABLE;
                    cnt_d   = 16'd0;
                end
            endcase
        end

        assign debounced[i]  = lvl_q;
        assign level_next[i] = lvl_d;
    end

    assign rise = level_next & ~debounced;
    assign clr  = (dwrite && addr == EDGE_ADDR) ? dwdata[2:0] : 3'b000;

    // Clear first, then OR in new rises so a same-cycle rise survives the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_q <= 3'b000;
        end else begin
            edge_q <= (edge_q & ~clr) | rise;
        end
    end

    always_comb begin
        rdata = 16'h0000;
        if (dread && addr == BASE_ADDR) begin
            rdata = {13'd0, debounced};
        end else if (dread && addr == EDGE_ADDR) begin
            rdata = {13'd0, edge_q};
        end
    end

    assign hit           = (addr == BASE_ADDR) || (addr == EDGE_ADDR);
    assign event_pending = |edge_q;

endmodule

// File: tb/tb_debounced_input_port.sv
// tb/tb_debounced_input_port.sv - directed scoreboard bench for debounced_input_port
module tb_debounced_input_port;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  sw;
    logic        btn;
    logic [15:0] addr;
    logic        dread;
    logic        dwrite;
    logic [15:0] dwdata;
    logic [15:0] rdata;
    logic        hit;
    logic        event_pending;

    int n_checks = 0;
    int n_fail   = 0;

    string       tag_q[$];
    logic [15:0] exp_q[$];

    debounced_input_port #(.DEBOUNCE_CYCLES(16), .BASE_ADDR(16'hFFF0)) dut (
        .clk           (clk),
        .reset         (reset),
        .sw            (sw),
        .btn           (btn),
        .addr          (addr),
        .dread         (dread),
        .dwrite        (dwrite),
        .dwdata        (dwdata),
        .rdata         (rdata),
        .hit           (hit),
        .event_pending (event_pending)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [15:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [15:0] obs);
        string       tag;
        logic [15:0] exp;
        tag = tag_q.pop_front();
        exp = exp_q.pop_front();
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [15:0] a);
        addr  = a;
        dread = 1'b1;
        #1;
    endtask

    task automatic wr_clear(input logic [15:0] data);
        addr   = 16'hFFF2;
        dwrite = 1'b1;
        dwdata = data;
        tick(1);
        dwrite = 1'b0;
        dwdata = 16'h0000;
    endtask

    initial begin
        reset = 1'b1; sw = 2'b00; btn = 1'b0;
        addr = 16'hFFF0; dread = 1'b1; dwrite = 1'b0; dwdata = 16'h0000;
        tick(2);
        expect_val("reset_status", 16'h0000);
        expect_val("reset_pending", 16'h0000);
        expect_val("reset_hit", 16'h0001);
        check(rdata);
        check({15'd0, event_pending});
        check({15'd0, hit});
        reset = 1'b0;
        tick(2);

        // Clean press
        btn = 1'b1;
        expect_val("press_pre", 16'h0000);
        expect_val("press_post", 16'h0004);
        expect_val("press_edge", 16'h0004);
        expect_val("press_pending", 16'h0001);
        tick(17); rd(16'hFFF0); check(rdata);
        tick(1);  rd(16'hFFF0); check(rdata);
        rd(16'hFFF2); check(rdata);
        check({15'd0, event_pending});

        // Bounce on sw[0]
        sw[0] = 1'b1; tick(5);
        sw[0] = 1'b0; tick(2);
        sw[0] = 1'b1;
        expect_val("bounce_pre", 16'h0004);
        expect_val("bounce_post", 16'h0005);
        expect_val("bounce_edge", 16'h0005);
        tick(17); rd(16'hFFF0); check(rdata);
        tick(1);  rd(16'hFFF0); check(rdata);
        rd(16'hFFF2); check(rdata);

        // Clear with read in the same cycle; upper write bits ignored
        expect_val("clear_preread", 16'h0005);
        expect_val("clear_after", 16'h0004);
        addr = 16'hFFF2; dread = 1'b1; dwrite = 1'b1; dwdata = 16'hFFF9;
        #1; check(rdata);
        tick(1);
        dwrite = 1'b0; dwdata = 16'h0000;
        rd(16'hFFF2); check(rdata);

        // Write to status address has no effect
        expect_val("status_wr_edge", 16'h0004);
        expect_val("status_wr_status", 16'h0005);
        addr = 16'hFFF0; dwrite = 1'b1; dwdata = 16'h0007;
        tick(1);
        dwrite = 1'b0;
        rd(16'hFFF2); check(rdata);
        rd(16'hFFF0); check(rdata);

        // Set-vs-clear collision on bit1
        sw[1] = 1'b1;
        expect_val("coll_pre", 16'h0005);
        expect_val("coll_edge", 16'h0006);
        expect_val("coll_status", 16'h0007);
        expect_val("bit1_clear", 16'h0004);
        tick(17); rd(16'hFFF0); check(rdata);
        wr_clear(16'h0002);
        rd(16'hFFF2); check(rdata);
        rd(16'hFFF0); check(rdata);
        wr_clear(16'h0002);
        rd(16'hFFF2); check(rdata);

        // Falling edge does not set the sticky bit
        wr_clear(16'h0007);
        btn = 1'b0;
        expect_val("fall_status", 16'h0003);
        expect_val("fall_edge", 16'h0000);
        expect_val("fall_pending", 16'h0000);
        tick(18);
        rd(16'hFFF0); check(rdata);
        rd(16'hFFF2); check(rdata);
        check({15'd0, event_pending});

        // Address decode
        expect_val("dec_fff4_rdata", 16'h0000);
        expect_val("dec_fff4_hit", 16'h0000);
        expect_val("dec_noread_rdata", 16'h0000);
        expect_val("dec_fff0_hit", 16'h0001);
        expect_val("dec_fff2_hit", 16'h0001);
        rd(16'hFFF4); check(rdata); check({15'd0, hit});
        addr = 16'hFFF0; dread = 1'b0; #1;
        check(rdata); check({15'd0, hit});
        addr = 16'hFFF2; #1; check({15'd0, hit});

        // Reset mid-count with btn held high
        btn = 1'b1;
        tick(12);
        reset = 1'b1;
        expect_val("rst_mid_status", 16'h0000);
        expect_val("rst_mid_pending", 16'h0000);
        rd(16'hFFF0); check(rdata);
        check({15'd0, event_pending});
        tick(1);
        reset = 1'b0;
        expect_val("rst_rel_pre", 16'h0000);
        expect_val("rst_rel_post", 16'h0007);
        expect_val("rst_rel_edge", 16'h0007);
        expect_val("rst_rel_pending", 16'h0001);
        tick(17); rd(16'hFFF0); check(rdata);
        tick(1);  rd(16'hFFF0); check(rdata);
        rd(16'hFFF2); check(rdata);
        check({15'd0, event_pending});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
